// File: rtl/glyph_dma_sched.sv
// glyph_dma_sched: shares one greeting ROM and one font ROM among SPR_CNT
// text sprites. A start pulse launches a run that, for each sprite in turn,
// reads the message code point, converts it to a glyph row address, reads the
// font ROM and strobes that sprite's one-hot DMA load line (4 cycles/sprite).
// Also owns message selection: msg advances every MSG_CHG frame pulses.
//
// Optional build macro: GLYPH_DMA_SKIP_SPACE_EN
//   When defined, the space glyph (cp == CP_START) is not fetched: font_addr
//   stays 0 in FT_REQ and spr_data is forced to 0 while the strobe still fires.
//
// Handshake: there is no backpressure. start is a one-cycle request honoured
// only while busy is low; a start seen while busy is dropped and recorded in
// the sticky overrun flag. dma_avail[i] is a one-cycle strobe that the sprite
// must accept unconditionally, qualified by spr_data in the same cycle.
module glyph_dma_sched #(
  parameter int SPR_CNT     = 8,
  parameter int MSG_CNT     = 32,
  parameter int MSG_LEN     = 16,
  parameter int MSG_CHG     = 80,
  parameter int CPW         = 7,
  parameter int FONT_HEIGHT = 8,
  parameter int FONT_GLYPHS = 64,
  parameter int CP_START    = 'h20,
  localparam int GLW = $clog2(FONT_HEIGHT),
  localparam int AW  = $clog2(MSG_CNT*MSG_LEN),
  localparam int FAW = $clog2(FONT_GLYPHS*FONT_HEIGHT),
  localparam int MW  = $clog2(MSG_CNT)
) (
  input  logic                   clk_pix,
  input  logic                   rst_pix_n,
  input  logic                   frame,
  input  logic                   start,
  input  logic                   row,
  input  logic [SPR_CNT*GLW-1:0] glyph_line,
  output logic [AW-1:0]          greet_addr,
  input  logic [CPW-1:0]         greet_data,
  output logic [FAW-1:0]         font_addr,
  input  logic [7:0]             font_data,
  output logic [7:0]             spr_data,
  output logic [SPR_CNT-1:0]     dma_avail,
  output logic [MW-1:0]          msg,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int IW  = $clog2(SPR_CNT);
  localparam int GIW = $clog2(FONT_GLYPHS);
  localparam int FCW = $clog2(MSG_CHG);
  localparam logic [CPW-1:0] CP_START_C = CPW'(CP_START);

  typedef enum logic [2:0] {
    S_IDLE, S_CP_REQ, S_CP_CAP, S_FT_REQ, S_FT_XFER, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   base_q, base_d;
  logic [CPW-1:0]  cp_q, cp_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [MW-1:0]   msg_q, msg_d;
  logic            overrun_q, overrun_d;

  logic [CPW-1:0]  cp_off;
  logic [GIW-1:0]  gidx;
  logic [GLW-1:0]  cur_line;
  logic            is_space;

  // Glyph index from the captured code point; anything below CP_START maps to glyph 0.
  always_comb begin
    cp_off   = cp_q - CP_START_C;
    gidx     = (cp_q < CP_START_C) ? '0 : cp_off[GIW-1:0];
    cur_line = glyph_line[idx_q*GLW +: GLW];
    is_space = (cp_q == CP_START_C);
  end

  // Next-state logic: frame counter / message index, run sequencing, overrun.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    cp_d      = cp_q;
    fcnt_d    = fcnt_q;
    msg_d     = msg_q;
    overrun_d = overrun_q;

    if (frame) begin
      if (fcnt_q == FCW'(MSG_CHG-1)) begin
        fcnt_d = '0;
        msg_d  = (msg_q == MW'(MSG_CNT-1)) ? '0 : msg_q + 1'b1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    if (start && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // msg_q is the pre-update value even when frame coincides with start.
          base_d  = AW'(msg_q) * AW'(MSG_LEN) + AW'(row) * AW'(SPR_CNT);
          idx_d   = '0;
          state_d = S_CP_REQ;
        end
      end
      S_CP_REQ: state_d = S_CP_CAP;
      S_CP_CAP: begin
        cp_d    = greet_data;
        state_d = S_FT_REQ;
      end
      S_FT_REQ: state_d = S_FT_XFER;
      S_FT_XFER: begin
        if (idx_q == IW'(SPR_CNT-1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_CP_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      base_q    <= '0;
      cp_q      <= '0;
      fcnt_q    <= '0;
      msg_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      cp_q      <= cp_d;
      fcnt_q    <= fcnt_d;
      msg_q     <= msg_d;
      overrun_q <= overrun_d;
    end
  end

  // ROM addresses and sprite strobe decoded from state; zero outside their state.
  always_comb begin
    greet_addr = '0;
    font_addr  = '0;
    spr_data   = '0;
    dma_avail  = '0;
    case (state_q)
      S_CP_REQ: greet_addr = base_q + AW'(idx_q);
      S_FT_REQ: begin
`ifdef GLYPH_DMA_SKIP_SPACE_EN
        if (!is_space) font_addr = FAW'(gidx) * FAW'(FONT_HEIGHT) + FAW'(cur_line);
`else
        font_addr = FAW'(gidx) * FAW'(FONT_HEIGHT) + FAW'(cur_line);
`endif
      end
      S_FT_XFER: begin
`ifdef GLYPH_DMA_SKIP_SPACE_EN
        spr_data = is_space ? 8'h00 : font_data;
`else
        spr_data = font_data;
`endif
        dma_avail = SPR_CNT'(1) << idx_q;
      end
      default: ;
    endcase
  end

`ifndef GLYPH_DMA_SKIP_SPACE_EN
  // Space detection only matters when space skipping is built in.
  logic unused_space;
  assign unused_space = is_space;
`endif

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign msg     = msg_q;
  assign overrun = overrun_q;

endmodule
